// File: rtl/c17_rsp_misr.sv
// rtl/c17_rsp_misr.sv - MISR compactor for c17 responses with pass/fail against a golden signature
// Optional response X-masking is enabled by defining C17_RSP_MASK_EN.
module c17_rsp_misr #(
    parameter int              SIG_W  = 16,
    parameter logic [SIG_W-1:0] POLY   = 16'h100B,
    parameter logic [SIG_W-1:0] SEED   = 16'h0000,
    parameter logic [15:0]      N_PAT  = 16'd32,
    parameter logic [SIG_W-1:0] GOLDEN = 16'h0000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             rsp_valid,
    input  logic             rsp_22,
    input  logic             rsp_23,
`ifdef C17_RSP_MASK_EN
    input  logic             rsp_mask,
`endif
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] signature,
    output logic [15:0]      pat_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [SIG_W-1:0] sig_q, sig_d;
    logic [15:0]      cnt_q, cnt_d;
    logic             pass_q, pass_d;
    logic             busy_q, done_q;
    logic [SIG_W-1:0] rsp_bits;
    logic [SIG_W-1:0] misr_next;
    logic [15:0]      cnt_inc;

    always_comb begin
        rsp_bits      = '0;
        rsp_bits[1:0] = {rsp_23, rsp_22};
`ifdef C17_RSP_MASK_EN
        // Masked responses still clock the MISR, they just inject nothing.
        if (rsp_mask) begin
            rsp_bits = '0;
        end
`endif
        misr_next = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0) ^ rsp_bits;
        cnt_inc   = cnt_q + 16'd1;
    end

    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    sig_d   = SEED;
                    cnt_d   = 16'd0;
                    pass_d  = 1'b0;
                end
            end
            RUN: begin
                if (rsp_valid) begin
                    sig_d = misr_next;
                    cnt_d = cnt_inc;
                    if (cnt_inc == N_PAT) begin
                        state_d = DONE;
                        pass_d  = (misr_next == GOLDEN);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sig_q   <= SEED;
            cnt_q   <= 16'd0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
            busy_q  <= (state_d == RUN);
            done_q  <= (state_d == DONE);
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign signature = sig_q;
    assign pat_cnt   = cnt_q;

endmodule

// File: tb/tb_c17_rsp_misr.sv
// tb/tb_c17_rsp_misr.sv - directed bench for c17_rsp_misr over three parameter sets with a run-level model
module tb_c17_rsp_misr;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  st = '0;
    logic [2:0]  vl = '0;
    logic [2:0]  r22 = '0;
    logic [2:0]  r23 = '0;
    logic [2:0]  mk = '0;
    logic [2:0]  busy_w, done_w, pass_w;
    logic [15:0] sig_w [3];
    logic [15:0] cnt_w [3];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    c17_rsp_misr #(.SIG_W(16), .POLY(16'h100B), .SEED(16'h0000), .N_PAT(16'd2), .GOLDEN(16'h0000)) u_a (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .rsp_valid(vl[0]), .rsp_22(r22[0]), .rsp_23(r23[0]),
`ifdef C17_RSP_MASK_EN
        .rsp_mask(mk[0]),
`endif
        .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]), .signature(sig_w[0]), .pat_cnt(cnt_w[0]));

    c17_rsp_misr #(.SIG_W(16), .POLY(16'h100B), .SEED(16'h8000), .N_PAT(16'd1), .GOLDEN(16'h0000)) u_b (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .rsp_valid(vl[1]), .rsp_22(r22[1]), .rsp_23(r23[1]),
`ifdef C17_RSP_MASK_EN
        .rsp_mask(mk[1]),
`endif
        .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]), .signature(sig_w[1]), .pat_cnt(cnt_w[1]));

    c17_rsp_misr #(.SIG_W(16), .POLY(16'h100B), .SEED(16'h0000), .N_PAT(16'd4), .GOLDEN(16'h001B)) u_c (
        .clk(clk), .rst_n(rst_n), .start(st[2]), .rsp_valid(vl[2]), .rsp_22(r22[2]), .rsp_23(r23[2]),
`ifdef C17_RSP_MASK_EN
        .rsp_mask(mk[2]),
`endif
        .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]), .signature(sig_w[2]), .pat_cnt(cnt_w[2]));

    function automatic int seed_of(int i);
        return (i == 1) ? 32'h8000 : 0;
    endfunction

    function automatic int npat_of(int i);
        case (i)
            0:       return 2;
            1:       return 1;
            default: return 4;
        endcase
    endfunction

    function automatic int gold_of(int i);
        return (i == 2) ? 32'h001B : 0;
    endfunction

    // Signature as polynomial arithmetic: multiply by x, reduce modulo the 17-bit polynomial, add response.
    function automatic int step(int s, int d);
        int w;
        w = s * 2;
        if (w >= 65536) w = (w - 65536) ^ 32'h100B;
        return w ^ d;
    endfunction

    function automatic int resp_of(int i);
`ifdef C17_RSP_MASK_EN
        if (mk[i]) return 0;
`endif
        return int'(r23[i]) * 2 + int'(r22[i]);
    endfunction

    // Model: 0 = idle, 1 = running, 2 = finished
    int m_mode [3];
    int m_sig  [3];
    int m_cnt  [3];
    int m_pass [3];

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                m_mode[i] <= 0;
                m_sig[i]  <= seed_of(i);
                m_cnt[i]  <= 0;
                m_pass[i] <= 0;
            end else if (m_mode[i] != 1) begin
                if (st[i]) begin
                    m_mode[i] <= 1;
                    m_sig[i]  <= seed_of(i);
                    m_cnt[i]  <= 0;
                end
            end else if (vl[i]) begin
                m_sig[i] <= step(m_sig[i], resp_of(i));
                m_cnt[i] <= m_cnt[i] + 1;
                if (m_cnt[i] + 1 == npat_of(i)) begin
                    m_mode[i] <= 2;
                    m_pass[i] <= (step(m_sig[i], resp_of(i)) == gold_of(i)) ? 1 : 0;
                end
            end
        end
    end

    task automatic chk(input string name, input int idx, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %0h expected %0h at %0t", name, idx, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            chk("m_busy", i, int'(busy_w[i]), (m_mode[i] == 1) ? 1 : 0);
            chk("m_done", i, int'(done_w[i]), (m_mode[i] == 2) ? 1 : 0);
            chk("m_sig",  i, int'(sig_w[i]), m_sig[i]);
            chk("m_cnt",  i, int'(cnt_w[i]), m_cnt[i]);
            if (m_mode[i] == 2) chk("m_pass", i, int'(pass_w[i]), m_pass[i]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input bit s, input bit v, input bit b23, input bit b22);
        st[i]  = s;
        vl[i]  = v;
        r23[i] = b23;
        r22[i] = b22;
    endtask

    initial begin
        tick();
        tick();
        chk("rst_sig", 0, int'(sig_w[0]), 0);
        chk("rst_cnt", 0, int'(cnt_w[0]), 0);
        chk("rst_busy", 0, int'(busy_w[0]), 0);
        chk("rst_done", 0, int'(done_w[0]), 0);
        chk("rst_pass", 0, int'(pass_w[0]), 0);
        chk("rst_sig", 1, int'(sig_w[1]), 32'h8000);
        rst_n = 1'b1;
        drive(0, 0, 1, 1, 1);
        tick();
        tick();
        chk("idle_hold_busy", 0, int'(busy_w[0]), 0);
        chk("idle_hold_sig", 0, int'(sig_w[0]), 0);

        // Two-pattern pass on instance A
        drive(0, 1, 0, 0, 0); tick();
        chk("a_busy", 0, int'(busy_w[0]), 1);
        drive(0, 0, 1, 0, 1); tick();
        chk("a_sig1", 0, int'(sig_w[0]), 32'h0001);
        chk("a_cnt1", 0, int'(cnt_w[0]), 1);
        drive(0, 0, 1, 1, 0); tick();
        drive(0, 0, 0, 0, 0);
        chk("a_sig2", 0, int'(sig_w[0]), 32'h0000);
        chk("a_done", 0, int'(done_w[0]), 1);
        chk("a_pass", 0, int'(pass_w[0]), 1);
        chk("a_cnt2", 0, int'(cnt_w[0]), 2);
        drive(0, 0, 1, 1, 1); tick(); tick();
        chk("a_hold_sig", 0, int'(sig_w[0]), 0);
        chk("a_hold_cnt", 0, int'(cnt_w[0]), 2);
        drive(0, 1, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0);
        chk("a_restart_busy", 0, int'(busy_w[0]), 1);
        chk("a_restart_done", 0, int'(done_w[0]), 0);
        chk("a_restart_cnt", 0, int'(cnt_w[0]), 0);

        // Feedback on instance B
        drive(1, 1, 0, 0, 0); tick();
        drive(1, 0, 1, 0, 0); tick();
        drive(1, 0, 0, 0, 0);
        chk("b_sig", 1, int'(sig_w[1]), 32'h100B);
        chk("b_done", 1, int'(done_w[1]), 1);
        chk("b_pass", 1, int'(pass_w[1]), 0);
        drive(1, 1, 0, 0, 0); tick();
        drive(1, 0, 0, 0, 0);
        chk("b_restart_sig", 1, int'(sig_w[1]), 32'h8000);
        chk("b_restart_busy", 1, int'(busy_w[1]), 1);
        chk("b_restart_cnt", 1, int'(cnt_w[1]), 0);
        drive(1, 0, 1, 1, 1); tick();
        drive(1, 0, 0, 0, 0);
        chk("b_sig2", 1, int'(sig_w[1]), 32'h1008);

        // Gaps and start during RUN on instance C
        drive(2, 1, 0, 0, 0); tick();
        drive(2, 0, 1, 1, 1); tick();
        drive(2, 0, 0, 1, 0); tick();
        drive(2, 1, 1, 0, 1); tick();
        drive(2, 0, 0, 1, 1); tick();
        drive(2, 0, 1, 1, 0); tick();
        drive(2, 0, 0, 0, 1); tick();
        chk("c_cnt3", 2, int'(cnt_w[2]), 3);
        chk("c_done3", 2, int'(done_w[2]), 0);
        chk("c_sig3", 2, int'(sig_w[2]), 32'h000C);
        drive(2, 0, 1, 1, 1); tick();
        drive(2, 0, 1, 0, 1); tick();
        drive(2, 0, 0, 0, 0);
        chk("c_sig", 2, int'(sig_w[2]), 32'h001B);
        chk("c_done", 2, int'(done_w[2]), 1);
        chk("c_pass", 2, int'(pass_w[2]), 1);
        chk("c_cnt", 2, int'(cnt_w[2]), 4);

`ifdef C17_RSP_MASK_EN
        mk[0] = 1'b1;
        drive(0, 0, 1, 1, 1); tick();
        mk[0] = 1'b0;
        chk("mask_sig", 0, int'(sig_w[0]), 0);
        chk("mask_cnt", 0, int'(cnt_w[0]), 1);
        drive(0, 0, 1, 0, 0); tick();
        drive(0, 0, 0, 0, 0);
        chk("mask_done", 0, int'(done_w[0]), 1);
        chk("mask_pass", 0, int'(pass_w[0]), 1);
`endif

        // Asynchronous reset in the middle of a run
        drive(2, 1, 0, 0, 0); tick();
        drive(2, 0, 1, 1, 1); tick();
        drive(2, 0, 0, 0, 0);
        chk("c_mid_sig", 2, int'(sig_w[2]), 32'h0003);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_sig", 2, int'(sig_w[2]), 0);
        chk("arst_cnt", 2, int'(cnt_w[2]), 0);
        chk("arst_busy", 2, int'(busy_w[2]), 0);
        chk("arst_done", 2, int'(done_w[2]), 0);
        chk("arst_pass", 2, int'(pass_w[2]), 0);
        chk("arst_sig", 1, int'(sig_w[1]), 32'h8000);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("post_rst_busy", 2, int'(busy_w[2]), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
